// File: rtl/pixel_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : pixel_sequencer
//  Description : Frame-level raster controller for the ray-marcher datapath.
//                Issues one Q11.21 coordinate pair per slot and throttles
//                issue with an in-flight credit count. Returns shades in
//                raster order on a ready/valid stream with SOF/EOL markers.
//  Revision    : 1.0 - initial release
// ============================================================================
module pixel_sequencer #(
    parameter int H_RES        = 640,
    parameter int V_RES        = 480,
    parameter int MAX_INFLIGHT = 8,
    parameter int FP_W         = 32,
    parameter int FRAC         = 21
) (
    input  logic            clk,
    input  logic            rst_gen,
    input  logic            start,
    output logic            busy,
    output logic            frame_done,
    output logic            err,
    output logic [FP_W-1:0] pix_x,
    output logic [FP_W-1:0] pix_y,
    output logic            pix_valid,
    input  logic            res_valid,
    input  logic [23:0]     res_shade,
    output logic [23:0]     out_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_sof,
    output logic            out_eol
);

    localparam int c_XW = (H_RES > 1) ? $clog2(H_RES) : 1;
    localparam int c_YW = (V_RES > 1) ? $clog2(V_RES) : 1;
    localparam int c_AW = $clog2(MAX_INFLIGHT);
    localparam int c_OW = c_AW + 1;

    localparam logic [c_XW-1:0] c_X_LAST = c_XW'(H_RES - 1);
    localparam logic [c_YW-1:0] c_Y_LAST = c_YW'(V_RES - 1);
    localparam logic [c_XW-1:0] c_X_ONE  = c_XW'(1);
    localparam logic [c_YW-1:0] c_Y_ONE  = c_YW'(1);
    localparam logic [c_AW-1:0] c_A_ONE  = c_AW'(1);
    localparam logic [c_OW-1:0] c_O_ONE  = c_OW'(1);
    localparam logic [c_OW-1:0] c_O_MAX  = c_OW'(MAX_INFLIGHT);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_RUN   = 2'd1;
    localparam logic [1:0] c_DRAIN = 2'd2;

    logic [1:0]      r_state;
    logic [c_XW-1:0] r_x;
    logic [c_YW-1:0] r_y;
    logic [c_XW-1:0] r_ox;
    logic [c_YW-1:0] r_oy;
    logic [c_OW-1:0] r_outstanding;
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_OW-1:0] r_count;
    logic [23:0]     r_mem [MAX_INFLIGHT];
    logic            r_busy;
    logic            r_frame_done;
    logic            r_err;
    logic            r_pix_valid;
    logic [FP_W-1:0] r_pix_x;
    logic [FP_W-1:0] r_pix_y;

    logic            w_start_acc;
    logic            w_out_valid;
    logic            w_hs;
    logic            w_full;
    logic [c_OW-1:0] w_inflight;
    logic            w_wr;
    logic            w_res_bad;
    logic            w_issue;
    logic [c_OW-1:0] w_out_next;

    assign w_start_acc = (r_state == c_IDLE) && start;
    assign w_out_valid = (r_count != '0);
    assign w_hs        = w_out_valid && out_ready;
    assign w_full      = (r_count == c_O_MAX);
    // Pixels issued whose results have not yet come back from the datapath.
    assign w_inflight  = r_outstanding - r_count;
    assign w_res_bad   = res_valid && (w_full || (w_inflight == '0));
    assign w_wr        = res_valid && !w_res_bad;
    assign w_issue     = (r_state == c_RUN) && (r_outstanding < c_O_MAX);

    // Next credit count: issue adds one, output handshake retires one.
    always_comb begin
        w_out_next = r_outstanding;
        if (w_issue && !w_hs) begin
            w_out_next = r_outstanding + c_O_ONE;
        end else if (!w_issue && w_hs) begin
            w_out_next = r_outstanding - c_O_ONE;
        end
    end

    // Frame FSM and coordinate issue; busy lags the state by one cycle so it
    // rises together with the first pix_valid and falls after frame_done.
    always_ff @(posedge clk or negedge rst_gen) begin
        if (!rst_gen) begin
            r_state      <= c_IDLE;
            r_x          <= '0;
            r_y          <= '0;
            r_pix_valid  <= 1'b0;
            r_pix_x      <= '0;
            r_pix_y      <= '0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_busy       <= (r_state != c_IDLE);
            r_frame_done <= 1'b0;
            r_pix_valid  <= w_issue;
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_state <= c_RUN;
                        r_x     <= '0;
                        r_y     <= '0;
                    end
                end
                c_RUN: begin
                    if (w_issue) begin
                        r_pix_x <= {{(FP_W - c_XW){1'b0}}, r_x} << FRAC;
                        r_pix_y <= {{(FP_W - c_YW){1'b0}}, r_y} << FRAC;
                        if (r_x == c_X_LAST) begin
                            r_x <= '0;
                            if (r_y == c_Y_LAST) begin
                                r_y     <= '0;
                                r_state <= c_DRAIN;
                            end else begin
                                r_y <= r_y + c_Y_ONE;
                            end
                        end else begin
                            r_x <= r_x + c_X_ONE;
                        end
                    end
                end
                c_DRAIN: begin
                    if (w_out_next == '0) begin
                        r_state      <= c_IDLE;
                        r_frame_done <= 1'b1;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    // Credit counter of pixels issued but not yet accepted downstream.
    always_ff @(posedge clk or negedge rst_gen) begin
        if (!rst_gen) begin
            r_outstanding <= '0;
        end else if (w_start_acc) begin
            r_outstanding <= '0;
        end else begin
            r_outstanding <= w_out_next;
        end
    end

    // Result FIFO pointers and occupancy; simultaneous write and read keep count.
    always_ff @(posedge clk or negedge rst_gen) begin
        if (!rst_gen) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (w_start_acc) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + c_A_ONE;
            end
            if (w_hs) begin
                r_rd_ptr <= r_rd_ptr + c_A_ONE;
            end
            if (w_wr && !w_hs) begin
                r_count <= r_count + c_O_ONE;
            end else if (!w_wr && w_hs) begin
                r_count <= r_count - c_O_ONE;
            end
        end
    end

    // Result FIFO storage; contents are only visible while occupancy is nonzero.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= res_shade;
        end
    end

    // Output-side raster position used for the SOF/EOL markers.
    always_ff @(posedge clk or negedge rst_gen) begin
        if (!rst_gen) begin
            r_ox <= '0;
            r_oy <= '0;
        end else if (w_start_acc) begin
            r_ox <= '0;
            r_oy <= '0;
        end else if (w_hs) begin
            if (r_ox == c_X_LAST) begin
                r_ox <= '0;
                r_oy <= (r_oy == c_Y_LAST) ? '0 : r_oy + c_Y_ONE;
            end else begin
                r_ox <= r_ox + c_X_ONE;
            end
        end
    end

    // Sticky protocol error: result with a full FIFO or with nothing in flight.
    always_ff @(posedge clk or negedge rst_gen) begin
        if (!rst_gen) begin
            r_err <= 1'b0;
        end else if (w_start_acc) begin
            r_err <= 1'b0;
        end else if (w_res_bad) begin
            r_err <= 1'b1;
        end
    end

    assign busy       = r_busy;
    assign frame_done = r_frame_done;
    assign err        = r_err;
    assign pix_x      = r_pix_x;
    assign pix_y      = r_pix_y;
    assign pix_valid  = r_pix_valid;
    assign out_valid  = w_out_valid;
    assign out_data   = w_out_valid ? r_mem[r_rd_ptr] : 24'd0;
    assign out_sof    = w_out_valid && (r_ox == '0) && (r_oy == '0);
    assign out_eol    = w_out_valid && (r_ox == c_X_LAST);

endmodule
`default_nettype wire

// File: tb/tb_pixel_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pixel_sequencer
//  Description : Directed bench for pixel_sequencer on a 4x2 raster with
//                fixed-latency datapath models (A: 8 credits, latency 5;
//                B: 4 credits, latency 3).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pixel_sequencer;

    localparam int H     = 4;
    localparam int V     = 2;
    localparam int LAT_A = 5;
    localparam int LAT_B = 3;

    logic clk     = 1'b0;
    logic rst_gen = 1'b0;
    always #5 clk = ~clk;

    logic        start_a = 1'b0, start_b = 1'b0;
    logic        out_ready_a = 1'b0, out_ready_b = 1'b0;
    logic        spur_a = 1'b0;
    logic        busy_a, frame_done_a, err_a, pix_valid_a, out_valid_a, out_sof_a, out_eol_a;
    logic        busy_b, frame_done_b, err_b, pix_valid_b, out_valid_b, out_sof_b, out_eol_b;
    logic [31:0] pix_x_a, pix_y_a, pix_x_b, pix_y_b;
    logic [23:0] out_data_a, out_data_b;
    logic        res_valid_a, res_valid_b;
    logic [23:0] res_shade_a, res_shade_b;

    int vectors     = 0;
    int miscompares = 0;

    pixel_sequencer #(.H_RES(H), .V_RES(V), .MAX_INFLIGHT(8), .FP_W(32), .FRAC(21)) dut_a (
        .clk(clk), .rst_gen(rst_gen), .start(start_a), .busy(busy_a),
        .frame_done(frame_done_a), .err(err_a), .pix_x(pix_x_a), .pix_y(pix_y_a),
        .pix_valid(pix_valid_a), .res_valid(res_valid_a), .res_shade(res_shade_a),
        .out_data(out_data_a), .out_valid(out_valid_a), .out_ready(out_ready_a),
        .out_sof(out_sof_a), .out_eol(out_eol_a)
    );

    pixel_sequencer #(.H_RES(H), .V_RES(V), .MAX_INFLIGHT(4), .FP_W(32), .FRAC(21)) dut_b (
        .clk(clk), .rst_gen(rst_gen), .start(start_b), .busy(busy_b),
        .frame_done(frame_done_b), .err(err_b), .pix_x(pix_x_b), .pix_y(pix_y_b),
        .pix_valid(pix_valid_b), .res_valid(res_valid_b), .res_shade(res_shade_b),
        .out_data(out_data_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
        .out_sof(out_sof_b), .out_eol(out_eol_b)
    );

    // Datapath models: non-stallable shift registers, not tied to rst_gen.
    logic [LAT_A-1:0] sra_v = '0;
    logic [23:0]      sra_d [LAT_A];
    logic [LAT_B-1:0] srb_v = '0;
    logic [23:0]      srb_d [LAT_B];

    always @(posedge clk) begin
        sra_v    <= {sra_v[LAT_A-2:0], pix_valid_a};
        sra_d[0] <= {pix_x_a[28:21], pix_y_a[28:21], 8'hA5};
        for (int i = 1; i < LAT_A; i++) sra_d[i] <= sra_d[i-1];
        srb_v    <= {srb_v[LAT_B-2:0], pix_valid_b};
        srb_d[0] <= {pix_x_b[28:21], pix_y_b[28:21], 8'hA5};
        for (int i = 1; i < LAT_B; i++) srb_d[i] <= srb_d[i-1];
    end

    assign res_valid_a = sra_v[LAT_A-1] | spur_a;
    assign res_shade_a = sra_d[LAT_A-1];
    assign res_valid_b = srb_v[LAT_B-1];
    assign res_shade_b = srb_d[LAT_B-1];

    function automatic logic [23:0] shade(input int idx);
        shade = {8'(idx % H), 8'(idx / H), 8'hA5};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full frame on instance A with out_ready held high; optionally pulses
    // start while in RUN (k=3) and DRAIN (k=10), which must be ignored.
    task automatic frame_a(input bit pulses);
        int          n_iss, n_hs, n_fd, k_first, k_last, k_fd, k_lasths;
        logic        busy_first, busy_fd, busy_after;
        logic [31:0] ex, ey;
        n_iss = 0; n_hs = 0; n_fd = 0;
        k_first = -1; k_last = -1; k_fd = -100; k_lasths = -1;
        busy_first = 1'bx; busy_fd = 1'bx; busy_after = 1'bx;
        out_ready_a = 1'b1;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (pulses) start_a = (k == 3) || (k == 10);
            if (k == 1) busy_first = busy_a;
            if (pix_valid_a) begin
                if (n_iss == 0) k_first = k;
                k_last = k;
                ex = 32'(n_iss % H) << 21;
                ey = 32'(n_iss / H) << 21;
                chk("pix_x", pix_x_a, ex);
                chk("pix_y", pix_y_a, ey);
                n_iss++;
            end
            if (out_valid_a && out_ready_a) begin
                chk("out_data", out_data_a, shade(n_hs));
                chk("out_sof", out_sof_a, n_hs == 0);
                chk("out_eol", out_eol_a, (n_hs % H) == H - 1);
                n_hs++;
                k_lasths = k;
            end
            if (k == k_fd + 1) busy_after = busy_a;
            if (frame_done_a) begin
                n_fd++;
                k_fd = k;
                busy_fd = busy_a;
            end
        end
        start_a = 1'b0;
        chk("issue_count", n_iss, 8);
        chk("first_issue_cycle", k_first, 1);
        chk("issue_span", k_last - k_first, 7);
        chk("busy_with_first_pixel", busy_first, 1'b1);
        chk("out_count", n_hs, 8);
        chk("last_handshake_cycle", k_lasths, 14);
        chk("frame_done_count", n_fd, 1);
        chk("frame_done_after_last_hs", k_fd, k_lasths + 1);
        chk("busy_at_frame_done", busy_fd, 1'b1);
        chk("busy_after_frame_done", busy_after, 1'b0);
        chk("err_after_frame", err_a, 1'b0);
    endtask

    initial begin
        int  n;
        int  idx;
        bit  fd;

        // Reset held with arbitrary input activity.
        start_a = 1'b1; start_b = 1'b1; out_ready_a = 1'b1; out_ready_b = 1'b1; spur_a = 1'b1;
        repeat (3) tick();
        chk("rst_busy", busy_a, 1'b0);
        chk("rst_frame_done", frame_done_a, 1'b0);
        chk("rst_err", err_a, 1'b0);
        chk("rst_pix_valid", pix_valid_a, 1'b0);
        chk("rst_out_valid", out_valid_a, 1'b0);
        chk("rst_out_sof", out_sof_a, 1'b0);
        chk("rst_out_eol", out_eol_a, 1'b0);
        chk("rst_pix_x", pix_x_a, 32'd0);
        chk("rst_pix_y", pix_y_a, 32'd0);
        chk("rst_out_data", out_data_a, 24'd0);
        chk("rst_b_busy", busy_b, 1'b0);
        start_a = 1'b0; start_b = 1'b0; spur_a = 1'b0; out_ready_a = 1'b0; out_ready_b = 1'b0;
        tick();
        rst_gen = 1'b1;

        // Released without start: no issue for 20 cycles.
        n = 0;
        repeat (20) begin
            tick();
            if (pix_valid_a || pix_valid_b || busy_a) n++;
        end
        chk("idle_no_issue", n, 0);

        // Two back-to-back frames; the second ignores start during RUN/DRAIN.
        frame_a(1'b0);
        frame_a(1'b1);

        // Backpressure on instance B.
        out_ready_b = 1'b0;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        n = 0;
        repeat (15) begin
            tick();
            if (pix_valid_b) n++;
        end
        chk("bp_issue_count", n, 4);
        chk("bp_pix_valid_stalled", pix_valid_b, 1'b0);
        chk("bp_out_valid", out_valid_b, 1'b1);
        chk("bp_outstanding", dut_b.r_outstanding, 3'd4);
        chk("bp_head_data", out_data_b, shade(0));
        chk("bp_head_sof", out_sof_b, 1'b1);
        out_ready_b = 1'b1;
        tick();
        out_ready_b = 1'b0;
        chk("bp_no_issue_at_accept", pix_valid_b, 1'b0);
        tick();
        chk("bp_one_issue", pix_valid_b, 1'b1);
        chk("bp_issue_x", pix_x_b, 32'h0);
        chk("bp_issue_y", pix_y_b, 32'h200000);
        tick();
        chk("bp_only_one_issue", pix_valid_b, 1'b0);
        out_ready_b = 1'b1;
        idx = 1;
        fd = 1'b0;
        for (int c = 0; c < 60 && !fd; c++) begin
            if (out_valid_b && out_ready_b) begin
                chk("bp_order", out_data_b, shade(idx));
                idx++;
            end
            if (frame_done_b) fd = 1'b1;
            else tick();
        end
        chk("bp_all_outputs", idx, 8);
        chk("bp_frame_done", fd, 1'b1);
        chk("bp_err", err_b, 1'b0);
        out_ready_b = 1'b0;

        // Reset mid-frame on A after three pixels reach the datapath.
        out_ready_a = 1'b1;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        repeat (4) tick();
        chk("mid_busy_before_reset", busy_a, 1'b1);
        rst_gen = 1'b0;
        #1;
        chk("async_rst_pix_valid", pix_valid_a, 1'b0);
        chk("async_rst_busy", busy_a, 1'b0);
        chk("async_rst_pix_x", pix_x_a, 32'd0);
        #1;
        rst_gen = 1'b1;
        repeat (2) tick();
        chk("err_before_late_results", err_a, 1'b0);
        repeat (3) tick();
        chk("err_late_results", err_a, 1'b1);
        chk("late_results_dropped", out_valid_a, 1'b0);

        // Next start clears err and runs a complete frame.
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        chk("start_clears_err", err_a, 1'b0);
        fd = 1'b0;
        for (int c = 0; c < 60 && !fd; c++) begin
            tick();
            if (frame_done_a) fd = 1'b1;
        end
        chk("recovery_frame_done", fd, 1'b1);
        repeat (2) tick();
        chk("recovery_err", err_a, 1'b0);

        // Spurious result while idle.
        spur_a = 1'b1;
        tick();
        spur_a = 1'b0;
        tick();
        chk("spurious_err", err_a, 1'b1);
        chk("spurious_out_valid", out_valid_a, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
